router_fsm: RTL and testbench

Packet-control state machine for the 1x3 router. It sits upstream of the three output FIFOs and the input data register. It decodes the 2-bit destination address of each incoming packet and sequences header, payload and parity loading. It throttles the source through `busy` and clears the packet when the addressed FIFO's soft reset fires.

---
 rtl/router_fsm.sv | 135 +++++++++++++
 tb/tb_router_fsm.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/router_fsm.sv
// Packet-control FSM for the 1x3 router: decodes the header address, sequences
// header/payload/parity loading, throttles the source and honours FIFO soft resets.
module router_fsm (
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg,
  output logic       busy,
  output logic [2:0] state_dbg,
  output logic [1:0] addr_dbg
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    FIFO_FULL_STATE    = 3'd3,
    LOAD_AFTER_FULL    = 3'd4,
    LOAD_PARITY        = 3'd5,
    CHECK_PARITY_ERROR = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] addr_q, addr_d;
  logic       hdr_empty;
  logic       addr_empty;
  logic       addr_soft_reset;

  // Source handshake: a byte on data_in is taken on a rising edge when
  // pkt_valid=1 and busy=0; while busy=1 the source must hold the same byte.

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= DECODE_ADDRESS;
      addr_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    hdr_empty       = 1'b0;
    addr_empty      = 1'b0;
    addr_soft_reset = 1'b0;
    case (data_in)
      2'd0:    hdr_empty = fifo_empty_0;
      2'd1:    hdr_empty = fifo_empty_1;
      2'd2:    hdr_empty = fifo_empty_2;
      default: hdr_empty = 1'b0;
    endcase
    // addr_q never holds 3, so the default arms are unreachable in practice.
    case (addr_q)
      2'd0:    begin addr_empty = fifo_empty_0; addr_soft_reset = soft_reset_0; end
      2'd1:    begin addr_empty = fifo_empty_1; addr_soft_reset = soft_reset_1; end
      2'd2:    begin addr_empty = fifo_empty_2; addr_soft_reset = soft_reset_2; end
      default: begin addr_empty = 1'b0;         addr_soft_reset = 1'b0;         end
    endcase
  end

  always_comb begin
    addr_d  = addr_q;
    state_d = state_q;

    if (state_q == DECODE_ADDRESS && pkt_valid && data_in != 2'd3) begin
      addr_d = data_in;
    end

    case (state_q)
      DECODE_ADDRESS: begin
        if (pkt_valid && data_in != 2'd3) begin
          state_d = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
      end
      LOAD_FIRST_DATA: state_d = LOAD_DATA;
      LOAD_DATA: begin
        if (fifo_full)       state_d = FIFO_FULL_STATE;
        else if (!pkt_valid) state_d = LOAD_PARITY;
      end
      FIFO_FULL_STATE: begin
        if (!fifo_full) state_d = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        if (parity_done)        state_d = DECODE_ADDRESS;
        else if (low_pkt_valid) state_d = LOAD_PARITY;
        else                    state_d = LOAD_DATA;
      end
      LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: begin
        state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      end
      WAIT_TILL_EMPTY: begin
        if (addr_empty) state_d = LOAD_FIRST_DATA;
      end
      default: state_d = DECODE_ADDRESS;
    endcase

    // Only the addressed FIFO's timeout can abort the packet.
    if (addr_soft_reset) state_d = DECODE_ADDRESS;
  end

  always_comb begin
    detect_add    = (state_q == DECODE_ADDRESS);
    lfd_state     = (state_q == LOAD_FIRST_DATA);
    ld_state      = (state_q == LOAD_DATA);
    laf_state     = (state_q == LOAD_AFTER_FULL);
    full_state    = (state_q == FIFO_FULL_STATE);
    rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
    write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_PARITY) ||
                    (state_q == LOAD_AFTER_FULL);
    busy          = (state_q == LOAD_FIRST_DATA) || (state_q == FIFO_FULL_STATE) ||
                    (state_q == LOAD_AFTER_FULL) || (state_q == LOAD_PARITY) ||
                    (state_q == CHECK_PARITY_ERROR) || (state_q == WAIT_TILL_EMPTY);
    state_dbg     = state_q;
    addr_dbg      = addr_q;
  end

endmodule

// File: tb/tb_router_fsm.sv
// Bench for router_fsm: directed packet scenarios followed by random traffic,
// every cycle compared against a named-state reference model.
module tb_router_fsm;

  logic       clock = 1'b0;
  logic       resetn;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       write_enb_reg, rst_int_reg, busy;
  logic [2:0] state_dbg;
  logic [1:0] addr_dbg;

  int    n_vec = 0;
  int    n_err = 0;
  string m_st  = "DA";
  int    m_addr = 0;
  int    rst_pulses = 0;

  router_fsm dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1),
    .fifo_empty_2(fifo_empty_2), .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1),
    .soft_reset_2(soft_reset_2), .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .write_enb_reg(write_enb_reg),
    .rst_int_reg(rst_int_reg), .busy(busy), .state_dbg(state_dbg), .addr_dbg(addr_dbg)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s (model state %s): got %0h expected %0h", tag, m_st, got, exp);
    end
  endtask

  // Reference model: applies the transition rules to named states.
  task automatic model_edge();
    bit    e[3];
    bit    sr[3];
    string nx;
    int    na;
    e  = '{fifo_empty_0, fifo_empty_1, fifo_empty_2};
    sr = '{soft_reset_0, soft_reset_1, soft_reset_2};
    nx = m_st;
    na = m_addr;
    if (m_st == "DA" && pkt_valid && data_in != 2'd3) na = data_in;
    if (m_st == "DA") begin
      if (pkt_valid && data_in != 2'd3) nx = e[data_in] ? "LFD" : "WTE";
    end else if (m_st == "LFD") nx = "LD";
    else if (m_st == "LD") begin
      if (fifo_full) nx = "FFS";
      else if (!pkt_valid) nx = "LP";
    end else if (m_st == "FFS") begin
      if (!fifo_full) nx = "LAF";
    end else if (m_st == "LAF") begin
      nx = parity_done ? "DA" : (low_pkt_valid ? "LP" : "LD");
    end else if (m_st == "LP") nx = "CPE";
    else if (m_st == "CPE") nx = fifo_full ? "FFS" : "DA";
    else if (m_st == "WTE") begin
      if (e[m_addr]) nx = "LFD";
    end
    if (sr[m_addr]) nx = "DA";
    if (!resetn) begin
      nx = "DA";
      na = 0;
    end
    m_st   = nx;
    m_addr = na;
  endtask

  task automatic check_outputs();
    chk("detect_add",    {1'b0, detect_add},    {1'b0, m_st == "DA"});
    chk("lfd_state",     {1'b0, lfd_state},     {1'b0, m_st == "LFD"});
    chk("ld_state",      {1'b0, ld_state},      {1'b0, m_st == "LD"});
    chk("laf_state",     {1'b0, laf_state},     {1'b0, m_st == "LAF"});
    chk("full_state",    {1'b0, full_state},    {1'b0, m_st == "FFS"});
    chk("rst_int_reg",   {1'b0, rst_int_reg},   {1'b0, m_st == "CPE"});
    chk("write_enb_reg", {1'b0, write_enb_reg},
        {1'b0, m_st == "LD" || m_st == "LP" || m_st == "LAF"});
    chk("busy",          {1'b0, busy},
        {1'b0, !(m_st == "DA" || m_st == "LD")});
    chk("addr_q", addr_dbg, 2'(m_addr));
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    if (rst_int_reg) rst_pulses++;
    check_outputs();
  endtask

  task automatic set_idle();
    resetn = 1'b1; pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
    fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
    soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
    parity_done = 1'b0; low_pkt_valid = 1'b0;
  endtask

  task automatic send_header(input logic [1:0] a);
    pkt_valid = 1'b1; data_in = a;
    step();
  endtask

  initial begin
    set_idle();
    // Reset held for two cycles.
    resetn = 1'b0;
    step(); step();
    chk("reset_detect_add", {1'b0, detect_add}, 2'd1);
    chk("reset_busy", {1'b0, busy}, 2'd0);
    resetn = 1'b1;

    // Normal packet to port 1: header, 3 payload, parity.
    rst_pulses = 0;
    send_header(2'd1);
    chk("hdr_lfd", {1'b0, lfd_state}, 2'd1);
    step(); step(); step();
    pkt_valid = 1'b0;
    step(); step(); step();
    chk("pkt1_back_in_da", {1'b0, detect_add}, 2'd1);
    chk("pkt1_rst_int_once", 2'(rst_pulses), 2'd1);

    // Invalid address 3: must stay in DA, addr unchanged.
    pkt_valid = 1'b1; data_in = 2'd3;
    repeat (4) step();
    chk("invalid_addr_hold", addr_dbg, 2'd1);
    pkt_valid = 1'b0;
    step();

    // Wait for empty on port 2.
    fifo_empty_2 = 1'b0;
    send_header(2'd2);
    pkt_valid = 1'b1;
    repeat (4) step();
    chk("wte_busy", {1'b0, busy}, 2'd1);
    fifo_empty_2 = 1'b1;
    step();
    chk("wte_to_lfd", {1'b0, lfd_state}, 2'd1);
    step();
    pkt_valid = 1'b0;
    step(); step(); step();

    // Full mid-packet, resume to LD, then low_pkt_valid path to LP.
    send_header(2'd0);
    step();
    fifo_full = 1'b1;
    step(); step(); step();
    chk("ffs_no_write", {1'b0, write_enb_reg}, 2'd0);
    fifo_full = 1'b0;
    step();
    step();
    chk("laf_to_ld", {1'b0, ld_state}, 2'd1);
    fifo_full = 1'b1;
    step();
    fifo_full = 1'b0;
    step();
    low_pkt_valid = 1'b1; pkt_valid = 1'b0;
    step();
    low_pkt_valid = 1'b0;
    step(); step();

    // Soft reset: non-addressed ignored, addressed aborts.
    send_header(2'd0);
    step();
    soft_reset_1 = 1'b1;
    step();
    chk("sr1_ignored", {1'b0, ld_state}, 2'd1);
    soft_reset_1 = 1'b0; soft_reset_0 = 1'b1;
    step();
    chk("sr0_abort", {1'b0, detect_add}, 2'd1);
    soft_reset_0 = 1'b0; pkt_valid = 1'b0;
    step();

    // Mid-packet synchronous reset clears addr.
    send_header(2'd2);
    step();
    resetn = 1'b0;
    step();
    chk("midpkt_reset_addr", addr_dbg, 2'd0);
    resetn = 1'b1;

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      resetn        = ($urandom_range(0, 99) != 0);
      pkt_valid     = ($urandom_range(0, 3) != 0);
      data_in       = 2'($urandom_range(0, 3));
      fifo_full     = ($urandom_range(0, 4) == 0);
      fifo_empty_0  = ($urandom_range(0, 3) != 0);
      fifo_empty_1  = ($urandom_range(0, 3) != 0);
      fifo_empty_2  = ($urandom_range(0, 3) != 0);
      soft_reset_0  = ($urandom_range(0, 24) == 0);
      soft_reset_1  = ($urandom_range(0, 24) == 0);
      soft_reset_2  = ($urandom_range(0, 24) == 0);
      parity_done   = ($urandom_range(0, 4) == 0);
      low_pkt_valid = ($urandom_range(0, 1) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
